// File: rtl/divider_fp.sv
// rtl/divider_fp.sv - IEEE-754 single-precision divider, restoring, truncating
module divider_fp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        ready,
    output logic [31:0] Y
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] NORM = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [1:0]  state;
    logic        sign_r;
    logic [7:0]  ea_r;
    logic [7:0]  eb_r;
    logic [24:0] rem;
    logic [23:0] dvs;
    logic [24:0] quo;
    logic [4:0]  cnt;

    logic        accept;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        sgn;
    logic        special;
    logic [31:0] special_y;

    logic        q_bit;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    logic signed [9:0] exp_w;
    logic [22:0] frac_n;
    logic [31:0] norm_y;

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Denormals are flushed: exponent 0 counts as zero regardless of fraction.
    assign a_zero = (A[30:23] == 8'd0);
    assign b_zero = (B[30:23] == 8'd0);
    assign a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    assign b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    assign a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    assign b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    assign sgn    = A[31] ^ B[31];

    always_comb begin
        special   = 1'b1;
        special_y = 32'd0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_y = QNAN;
        end else if (a_inf || b_zero) begin
            special_y = {sgn, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            special_y = {sgn, 31'd0};
        end else begin
            special   = 1'b0;
        end
    end

    // Remainder stays below twice the divisor, so 25 bits hold it after the shift.
    assign q_bit    = (rem >= {1'b0, dvs});
    assign rem_sub  = rem - {1'b0, dvs};
    assign rem_next = q_bit ? {rem_sub[23:0], 1'b0} : {rem[23:0], 1'b0};

    always_comb begin
        exp_w  = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r})
               + (quo[24] ? 10'sd127 : 10'sd126);
        frac_n = quo[24] ? quo[23:1] : quo[22:0];
        if (exp_w >= 10'sd255) begin
            norm_y = {sign_r, 8'hFF, 23'd0};
        end else if (exp_w <= 10'sd0) begin
            norm_y = {sign_r, 31'd0};
        end else begin
            norm_y = {sign_r, exp_w[7:0], frac_n};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ready  <= 1'b0;
            Y      <= 32'd0;
            sign_r <= 1'b0;
            ea_r   <= 8'd0;
            eb_r   <= 8'd0;
            rem    <= 25'd0;
            dvs    <= 24'd0;
            quo    <= 25'd0;
            cnt    <= 5'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        sign_r <= sgn;
                        ea_r   <= A[30:23];
                        eb_r   <= B[30:23];
                        if (special) begin
                            Y     <= special_y;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            rem   <= {2'b01, A[22:0]};
                            dvs   <= {1'b1, B[22:0]};
                            quo   <= 25'd0;
                            cnt   <= 5'd0;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= {quo[23:0], q_bit};
                    if (cnt == 5'd24) begin
                        cnt   <= 5'd0;
                        state <= NORM;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                NORM: begin
                    Y     <= norm_y;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_fp.sv
// tb/tb_divider_fp.sv - randomized and directed bench for divider_fp
module tb_divider_fp;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        ready;
    logic [31:0] Y;

    int tests;
    int errors;

    divider_fp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .ready (ready),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit 32 flags a special-case result that is ready right after the accepting edge.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e;
        longint ma, mb, q;
        logic s, az, bz, ai, bi, an, bn;
        logic [7:0]  e8;
        logic [22:0] fr;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 32'h7FC00000};
        if (ai || bz) return {1'b1, s, 8'hFF, 23'd0};
        if (az || bi) return {1'b1, s, 31'd0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        q  = (ma * 64'd16777216) / mb;
        if (q >= 64'd16777216) begin
            e  = ea - eb + 127;
            fr = 23'((q / 2) % 64'd8388608);
        end else begin
            e  = ea - eb + 126;
            fr = 23'(q % 64'd8388608);
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        e8 = e[7:0];
        return {1'b0, s, e8, fr};
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inject_at);
        logic [32:0] m;
        int n;
        m = model(a, b);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        if (m[32]) begin
            check("special_ready", ready, 1);
            check("special_busy", busy, 0);
            check("special_y", Y, m[31:0]);
        end else begin
            check("edge0_busy", busy, 1);
            check("edge0_ready", ready, 0);
            n = 0;
            while (!ready && n < 40) begin
                if (n == inject_at) begin
                    start = 1'b1;
                    A = $urandom;
                    B = $urandom;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                n++;
                if (busy && ready) check("busy_and_ready", 1, 0);
            end
            start = 1'b0;
            check("latency", n, 26);
            check("done_busy", busy, 0);
            check("normal_y", Y, m[31:0]);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [7:0]  e;
        logic [22:0] f;
        int sel;
        sel = $urandom_range(0, 11);
        f = 23'($urandom);
        case (sel)
            0: e = 8'd0;
            1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'd0; end
            2: e = 8'd1;
            3: e = 8'd254;
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    logic [31:0] dir_a [10];
    logic [31:0] dir_b [10];

    initial begin
        int stale;
        tests  = 0;
        errors = 0;
        start  = 1'b0;
        A      = 32'd0;
        B      = 32'd0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_ready", ready, 0);
        check("reset_y", Y, 32'd0);
        repeat (3) @(negedge clk);
        check("reset_hold_ready", ready, 0);
        rst_n = 1'b1;

        dir_a = '{32'h40C00000, 32'h41A00000, 32'h3F800000, 32'h00000000, 32'h40A00000,
                  32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000, 32'h7FC12345};
        dir_b = '{32'h41A00000, 32'hC0800000, 32'h40400000, 32'h00000000, 32'h00000000,
                  32'h40A00000, 32'h7F800000, 32'h3E800000, 32'h40000000, 32'h3F800000};
        for (int i = 0; i < 10; i++) run_op(dir_a[i], dir_b[i], -1);

        check("anchor_6_20", model(32'h40C00000, 32'h41A00000), {1'b0, 32'h3E999999});
        check("anchor_20_m4", model(32'h41A00000, 32'hC0800000), {1'b0, 32'hC0A00000});
        check("anchor_1_3", model(32'h3F800000, 32'h40400000), {1'b0, 32'h3EAAAAAA});

        run_op(32'h40C00000, 32'h41A00000, 10);
        run_op(32'h3F800000, 32'h40400000, -1);

        A = 32'h41A00000;
        B = 32'hC0800000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_y", Y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (ready || busy || Y != 32'd0) stale++;
        end
        check("no_stale_result", stale, 0);
        run_op(32'h41A00000, 32'hC0800000, -1);

        for (int i = 0; i < 200; i++) run_op(rand_operand(), rand_operand(), -1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
